// File: rtl/qsystd_irq_ctrl.sv
// qsystd_irq_ctrl: Avalon-MM interrupt controller with synchronized sources,
// per-source edge/level capture, masking, priority vector and irq_out rise counter.
module qsystd_irq_ctrl #(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq_out
);

   localparam int unsigned DW = 16;
   localparam int unsigned IW = 4;

   localparam logic [2:0] A_PENDING = 3'd0;
   localparam logic [2:0] A_MASK    = 3'd1;
   localparam logic [2:0] A_EDGE    = 3'd2;
   localparam logic [2:0] A_ACTIVE  = 3'd3;
   localparam logic [2:0] A_VECTOR  = 3'd4;
   localparam logic [2:0] A_FORCE   = 3'd5;
   localparam logic [2:0] A_COUNT   = 3'd6;
   localparam logic [2:0] A_RAW     = 3'd7;

   logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] edge_q, edge_d;
   logic [DW-1:0]      count_q, count_d;
   logic [DW-1:0]      readdata_q, readdata_d;
   logic               irq_out_q, irq_out_d;

   logic               wr_en;
   logic               irq_rise;
   logic [NUM_IRQ-1:0] wdata;
   logic [NUM_IRQ-1:0] set_bits;
   logic [NUM_IRQ-1:0] clr_bits;
   logic [NUM_IRQ-1:0] active;
   logic [IW-1:0]      vec_idx;
   logic [DW-1:0]      vector;
   logic               unused_wdata;

   assign wr_en  = chipselect && !write_n;
   assign wdata  = writedata[NUM_IRQ-1:0];
   assign active = pending_q & mask_q;
   // write-data bits above NUM_IRQ have no register behind them
   assign unused_wdata = ^writedata;

   // Two-flop synchronizer plus history flop for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= irq_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Configuration register writes
   always_comb begin
      mask_d = mask_q;
      edge_d = edge_q;
      if (wr_en && (address == A_MASK)) mask_d = wdata;
      if (wr_en && (address == A_EDGE)) edge_d = wdata;
   end

   // Edge sources latch until W1C (set wins); level sources follow s2
   always_comb begin
      set_bits  = (s2_q & ~s3_q) | (wdata & {NUM_IRQ{wr_en && (address == A_FORCE)}});
      clr_bits  = wdata & {NUM_IRQ{wr_en && (address == A_PENDING)}};
      pending_d = (edge_q & (set_bits | (pending_q & ~clr_bits))) | (~edge_q & s2_q);
   end

   // Lowest active index has priority
   always_comb begin
      vec_idx = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (active[i]) vec_idx = IW'(i);
      end
      vector = {|active, 11'b0, vec_idx};
   end

   // Aggregated irq and saturating rise counter; a clear on a rise clock leaves 1
   always_comb begin
      irq_out_d = |active;
      irq_rise  = irq_out_d && !irq_out_q;
      count_d   = count_q;
      if (wr_en && (address == A_COUNT)) begin
         count_d = irq_rise ? DW'(1) : '0;
      end else if (irq_rise && (count_q != {DW{1'b1}})) begin
         count_d = count_q + DW'(1);
      end
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         A_PENDING: readdata_d = DW'(pending_q);
         A_MASK:    readdata_d = DW'(mask_q);
         A_EDGE:    readdata_d = DW'(edge_q);
         A_ACTIVE:  readdata_d = DW'(active);
         A_VECTOR:  readdata_d = vector;
         A_FORCE:   readdata_d = '0;
         A_COUNT:   readdata_d = count_q;
         A_RAW:     readdata_d = DW'(s2_q);
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q  <= '0;
         mask_q     <= '0;
         edge_q     <= '0;
         count_q    <= '0;
         readdata_q <= '0;
         irq_out_q  <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         count_q    <= count_d;
         readdata_q <= readdata_d;
         irq_out_q  <= irq_out_d;
      end
   end

   assign readdata = readdata_q;
   assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_qsystd_irq_ctrl.sv
// Testbench for qsystd_irq_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the register map.
module tb_qsystd_irq_ctrl;

   localparam int unsigned N = 8;
   localparam logic [15:0] IMASK = 16'h00FF;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [2:0]    address = 3'd0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [15:0]   writedata = 16'h0;
   logic [15:0]   readdata;
   logic [N-1:0]  irq_in = '0;
   logic          irq_out;

   qsystd_irq_ctrl #(.NUM_IRQ(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq_out    (irq_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: register contents plus a delay line of sampled irq_in values
   logic [15:0] m_pend, m_mask, m_edge, m_cnt, exp_rd;
   logic        m_irq;
   logic [15:0] samp[$];

   function automatic logic [15:0] m_vector(input logic [15:0] act);
      for (int i = 0; i < 16; i++) if (act[i]) return 16'h8000 | 16'(i);
      return 16'h0000;
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_pend;
         3'd1:    return m_mask;
         3'd2:    return m_edge;
         3'd3:    return m_pend & m_mask;
         3'd4:    return m_vector(m_pend & m_mask);
         3'd5:    return 16'h0000;
         3'd6:    return m_cnt;
         default: return samp[1];
      endcase
   endfunction

   task automatic model_reset();
      m_pend = 16'h0; m_mask = 16'h0; m_edge = 16'h0; m_cnt = 16'h0;
      m_irq = 1'b0; exp_rd = 16'h0;
      samp = '{16'h0, 16'h0, 16'h0};
   endtask

   // Advance one clock: model computes the post-edge state from pre-edge inputs
   task automatic tick();
      logic        wr, nirq, rise;
      logic [15:0] wd, s2, s3, np;
      wr = chipselect && !write_n;
      wd = writedata & IMASK;
      s2 = samp[1];
      s3 = samp[2];
      exp_rd = m_read(address);
      np = m_pend;
      for (int i = 0; i < int'(N); i++) begin
         if (!m_edge[i]) np[i] = s2[i];
         else if ((s2[i] && !s3[i]) || (wr && address == 3'd5 && wd[i])) np[i] = 1'b1;
         else if (wr && address == 3'd0 && wd[i]) np[i] = 1'b0;
      end
      nirq = |(m_pend & m_mask);
      rise = nirq && !m_irq;
      if (wr && address == 3'd6) m_cnt = rise ? 16'h0001 : 16'h0000;
      else if (rise && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
      if (wr && address == 3'd1) m_mask = wd;
      if (wr && address == 3'd2) m_edge = wd;
      m_pend = np;
      m_irq  = nirq;
      samp.push_front(16'(irq_in));
      void'(samp.pop_back());
      @(posedge clk);
      #1;
   endtask

   task automatic set_write(input logic [2:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
   endtask

   task automatic set_read(input logic [2:0] a);
      address = a; writedata = 16'h0; chipselect = 1'b1; write_n = 1'b1;
   endtask

   task automatic set_idle();
      chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (readdata !== 16'h0) begin errors++; $display("FAIL reset_readdata got %h want 0000", readdata); end
      checks++;
      if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out got %b want 0", irq_out); end
      @(posedge clk); @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int a = 0; a < 8; a++) begin
         set_read(3'(a));
         tick();
         checks++;
         if (readdata !== 16'h0) begin errors++; $display("FAIL reset_read_addr%0d got %h want 0000", a, readdata); end
      end
      set_idle();
   endtask

   task automatic test_edge_pulse();
      set_write(3'd2, 16'h0001); tick();
      set_write(3'd1, 16'h0001); tick();
      set_read(3'd0);
      irq_in = N'(1);
      tick();                                 // E0
      irq_in = '0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         checks++;
         if (irq_out !== (e == 3)) begin errors++; $display("FAIL pulse_irq_out_E%0d got %b want %b", e, irq_out, e == 3); end
      end
      checks++;
      if (readdata !== 16'h0001) begin errors++; $display("FAIL pulse_pending got %h want 0001", readdata); end
      set_read(3'd6); tick();
      checks++;
      if (readdata !== 16'h0001) begin errors++; $display("FAIL pulse_count got %h want 0001", readdata); end
      set_write(3'd0, 16'h0001); tick();
      checks++;
      if (irq_out !== 1'b1) begin errors++; $display("FAIL pulse_w1c_early got %b want 1", irq_out); end
      set_idle(); tick();
      checks++;
      if (irq_out !== 1'b0) begin errors++; $display("FAIL pulse_w1c_clear got %b want 0", irq_out); end
   endtask

   task automatic test_level();
      set_write(3'd2, 16'h0000); tick();
      set_write(3'd1, 16'h0004); tick();
      set_idle();
      for (int n = 0; n < 16; n++) begin
         irq_in = (n < 10) ? N'(4) : N'(0);
         if (n == 5) set_write(3'd0, 16'h0004);
         else set_idle();
         tick();
         checks++;
         if (irq_out !== (n >= 3 && n <= 12)) begin
            errors++; $display("FAIL level_irq_out_E%0d got %b want %b", n, irq_out, (n >= 3 && n <= 12));
         end
      end
      set_idle();
   endtask

   task automatic test_vector();
      set_write(3'd1, 16'h00FF); tick();
      set_write(3'd2, 16'h00FF); tick();
      set_write(3'd5, 16'h0028); tick();
      set_read(3'd3); tick();
      checks++;
      if (readdata !== 16'h0028) begin errors++; $display("FAIL vec_active got %h want 0028", readdata); end
      set_read(3'd4); tick();
      checks++;
      if (readdata !== 16'h8003) begin errors++; $display("FAIL vec_first got %h want 8003", readdata); end
      set_write(3'd0, 16'h0008); tick();
      set_read(3'd4); tick();
      checks++;
      if (readdata !== 16'h8005) begin errors++; $display("FAIL vec_second got %h want 8005", readdata); end
      set_write(3'd0, 16'h0020); tick();
      set_read(3'd4); tick();
      checks++;
      if (readdata !== 16'h0000) begin errors++; $display("FAIL vec_none got %h want 0000", readdata); end
      checks++;
      if (irq_out !== 1'b0) begin errors++; $display("FAIL vec_irq_out got %b want 0", irq_out); end
      set_idle();
   endtask

   task automatic test_w1c_collision();
      irq_in = N'(2);
      set_idle(); tick(); tick();
      set_write(3'd0, 16'h0002); tick();      // edge detected on this clock
      set_read(3'd0); tick();
      checks++;
      if (readdata !== 16'h0002) begin errors++; $display("FAIL collision_set_wins got %h want 0002", readdata); end
      irq_in = '0;
      set_write(3'd0, 16'h0002); tick();
      set_read(3'd0); tick();
      checks++;
      if (readdata !== 16'h0000) begin errors++; $display("FAIL collision_cleanup got %h want 0000", readdata); end
      set_idle(); tick();
   endtask

   task automatic test_count_sat();
      force dut.count_q = 16'hFFFE;
      #1;
      release dut.count_q;
      m_cnt = 16'hFFFE;
      for (int r = 0; r < 2; r++) begin
         set_write(3'd5, 16'h0001); tick();
         set_idle(); tick();
         set_write(3'd0, 16'h0001); tick();
         set_idle(); tick();
         set_read(3'd6); tick();
         checks++;
         if (readdata !== 16'hFFFF) begin errors++; $display("FAIL count_sat_rise%0d got %h want ffff", r, readdata); end
      end
      set_write(3'd5, 16'h0001); tick();
      set_write(3'd6, 16'h0000); tick();      // rise on this clock
      set_read(3'd6); tick();
      checks++;
      if (readdata !== 16'h0001) begin errors++; $display("FAIL count_clear_on_rise got %h want 0001", readdata); end
      set_write(3'd0, 16'h0001); tick();
      set_idle(); tick();
   endtask

   task automatic test_reset_mid();
      set_write(3'd5, 16'h00FF); tick();
      set_idle(); tick(); tick();
      checks++;
      if (irq_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre_irq got %b want 1", irq_out); end
      #2;
      reset_n = 1'b0;
      irq_in = N'(1);
      #1;
      checks++;
      if (readdata !== 16'h0 || irq_out !== 1'b0) begin
         errors++; $display("FAIL rstmid_async got rd=%h irq=%b want 0000/0", readdata, irq_out);
      end
      @(posedge clk); @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      set_write(3'd2, 16'h0001); tick();
      set_write(3'd1, 16'h0001); tick();
      set_idle(); tick(); tick(); tick(); tick();
      set_read(3'd0); tick();
      checks++;
      if (readdata !== 16'h0001) begin errors++; $display("FAIL rstmid_edge_pending got %h want 0001", readdata); end
      set_write(3'd0, 16'h0001); tick();
      set_idle(); tick(); tick(); tick();
      set_read(3'd0); tick();
      checks++;
      if (readdata !== 16'h0000) begin errors++; $display("FAIL rstmid_no_reedge got %h want 0000", readdata); end
      set_read(3'd6); tick();
      checks++;
      if (readdata !== 16'h0001) begin errors++; $display("FAIL rstmid_count_once got %h want 0001", readdata); end
      irq_in = '0;
      set_idle(); tick(); tick(); tick();
   endtask

   task automatic test_random();
      int unsigned r;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
         r = $urandom_range(0, 9);
         if (r <= 2) set_write(3'($urandom_range(0, 7)), 16'($urandom));
         else if (r == 3) begin
            address = 3'($urandom_range(0, 7)); chipselect = 1'b0; write_n = 1'b0;
            writedata = 16'($urandom);
         end else set_read(3'($urandom_range(0, 7)));
         tick();
         checks++;
         if (readdata !== exp_rd) begin errors++; $display("FAIL rand_readdata cyc%0d got %h want %h", c, readdata, exp_rd); end
         checks++;
         if (irq_out !== m_irq) begin errors++; $display("FAIL rand_irq_out cyc%0d got %b want %b", c, irq_out, m_irq); end
      end
      set_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_edge_pulse();
      test_level();
      test_vector();
      test_w1c_collision();
      test_count_sat();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
